uart_tx_fifo: RTL

Buffered, parametrised UART transmitter, successor to the unbuffered Wishbone UART TX.
- Accepts words on a valid/ready stream into an internal FIFO.
- Serialises each word as start bit, DAT_WIDTH data bits (LSB first), optional parity bit, and 1 or 2 stop bits.
- Bit period is set by a runtime divisor.
- Sits behind a bus adapter (Wishbone or stream) and drives the board TX pin directly.

---
 rtl/uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with a stream-fed word FIFO
//
// uart_tx_fifo
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   div_i         clocks per bit (0 and 1 behave as 2), sampled at frame load
//   dat_i         word to transmit
//   valid_i       dat_i is valid; accepted on edges where ready_o is high
//   ready_o       FIFO can accept a word (not full)
//   uart_tx       serial line, idle high
//   busy_o        a frame is in progress
//   fifo_count_o  words waiting in the FIFO, excluding the word in flight
//
// uart_tx_fifo_buf
//   clk, rst                  clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tready write side
//   m_tdata/m_tvalid/m_tready read side (m_tdata is the head word)
//   count                     number of stored words

module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [WIDTH-1:0]             m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  // Full is taken from the registered count only, so a pop in the same
  // cycle never opens a slot early.
  assign s_tready = (count_q != CW'(DEPTH));
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = mem[rd_ptr];
  assign count    = count_q;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

endmodule

module uart_tx_fifo #(
  parameter int DAT_WIDTH  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DIV_WIDTH-1:0]             div_i,
  input  logic [DAT_WIDTH-1:0]             dat_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic                             uart_tx,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int BW = $clog2(DAT_WIDTH + 1);
  localparam logic [BW-1:0]        LAST_BIT  = BW'(DAT_WIDTH - 1);
  localparam logic [BW-1:0]        LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                 state;
  logic [DAT_WIDTH-1:0]   shreg;
  logic                   par_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   baud_cnt;
  logic [BW-1:0]          bit_cnt;

  logic [DAT_WIDTH-1:0]   fifo_data;
  logic                   fifo_valid;
  logic                   load;
  logic                   bit_end;
  logic [DIV_WIDTH-1:0]   div_eff;

  function automatic logic parity_of(input logic [DAT_WIDTH-1:0] d);
    // Even mode sends the XOR of the data bits, odd mode its inverse.
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  uart_tx_fifo_buf #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .s_tdata  (dat_i),
    .s_tvalid (valid_i),
    .s_tready (ready_o),
    .m_tdata  (fifo_data),
    .m_tvalid (fifo_valid),
    .m_tready (load),
    .count    (fifo_count_o)
  );

  assign div_eff = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign bit_end = (baud_cnt == div_q - DIV_WIDTH'(1));

  // A word is loaded from IDLE, or on the final clock of the last stop bit
  // so consecutive frames run with no idle gap.
  assign load = fifo_valid &&
                ((state == IDLE) ||
                 ((state == STOP) && bit_end && (bit_cnt == LAST_STOP)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      busy_o   <= 1'b0;
      shreg    <= '0;
      par_q    <= 1'b0;
      div_q    <= DIV_MIN;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      state    <= START;
      uart_tx  <= 1'b0;
      busy_o   <= 1'b1;
      shreg    <= fifo_data;
      par_q    <= parity_of(fifo_data);
      div_q    <= div_eff;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          busy_o  <= 1'b0;
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            uart_tx  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // shreg[0] is on the line; the next bit is presented from shreg[1]
        // while the register shifts down.
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state   <= PAR;
                uart_tx <= par_q;
              end else begin
                state   <= STOP;
                uart_tx <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        PAR: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= STOP;
            uart_tx  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // bit_cnt counts stop bits here.
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy_o  <= 1'b0;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
